// File: rtl/au_floating_point_seq_pkg.sv
// Shared types and helpers for the sequential floating-point unit.
// Widths are passed explicitly so one package serves every configuration.
package fpu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_UNPACK,
        S_SPECIAL,
        S_ALIGN,
        S_ADDSUB,
        S_MULT,
        S_DIV,
        S_NORM,
        S_PACK,
        S_DONE
    } fsm_t;

    function automatic int bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

    function automatic logic [127:0] canonical_nan(input int ew, input int mw);
        return (((128'(1) << ew) - 128'(1)) << mw) | (128'(1) << (mw - 1));
    endfunction

    function automatic logic [127:0] inf(input logic s, input int ew, input int mw);
        logic [127:0] v;
        v = ((128'(1) << ew) - 128'(1)) << mw;
        v[ew+mw] = s;
        return v;
    endfunction

    // Index of the most significant set bit, -1 when the vector is zero.
    function automatic int lead_one(input logic [127:0] v);
        int p;
        p = -1;
        for (int i = 0; i < 128; i++) begin
            if (v[i]) p = i;
        end
        return p;
    endfunction

endpackage

// File: rtl/au_floating_point_seq_if.sv
// Operand/result stream bundle for the sequential FPU.
// Both directions use a valid/ready handshake.
interface au_floating_point_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = EXP_W + MAN_W + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [1:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         overflag;
    logic         underflag;
    logic         invalid;

    modport master (
        output in_valid, A, B, sel, out_ready,
        input  in_ready, out_valid, result, overflag, underflag, invalid
    );

    modport slave (
        input  in_valid, A, B, sel, out_ready,
        output in_ready, out_valid, result, overflag, underflag, invalid
    );

endinterface

// File: rtl/au_floating_point_seq_divider.sv
// Restoring significand divider: one quotient bit per cycle,
// integer bit first, MAN_W+3 bits in total.
module fpu_seq_divider #(
    parameter int MAN_W = 23
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAN_W:0]     dividend,
    input  logic [MAN_W:0]     divisor,
    output logic               busy,
    output logic               done,
    output logic [MAN_W+2:0]   quotient
);
    localparam int SW = MAN_W + 1;
    localparam int QW = MAN_W + 3;
    localparam int CW = $clog2(QW + 1);

    logic [SW:0]   rem;
    logic [SW:0]   dsr;
    logic [SW:0]   nxt;
    logic [CW-1:0] cnt;
    logic          ge;

    assign ge   = rem >= dsr;
    assign nxt  = ge ? rem - dsr : rem;
    assign done = busy && (cnt == CW'(QW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dsr      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            quotient <= '0;
        end else if (start) begin
            rem      <= {1'b0, dividend};
            dsr      <= {1'b0, divisor};
            cnt      <= '0;
            busy     <= 1'b1;
            quotient <= '0;
        end else if (busy) begin
            quotient <= {quotient[QW-2:0], ge};
            rem      <= nxt << 1;
            cnt      <= cnt + 1'b1;
            if (done) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/au_floating_point_seq.sv
// Multi-cycle add/sub/mul/div floating-point unit, truncating,
// denormal inputs flushed to zero, stream handshakes on both sides.
module au_floating_point_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic clk,
    input logic rst_n,
    au_floating_point_seq_if.slave io
);
    localparam int W   = EXP_W + MAN_W + 1;
    localparam int SW  = MAN_W + 1;
    localparam int QW  = MAN_W + 3;
    localparam int MW  = 2 * SW;
    localparam int EW2 = EXP_W + 2;
    typedef logic signed [EW2-1:0] sexp_t;
    localparam sexp_t BIAS = sexp_t'(bias(EXP_W));
    localparam sexp_t EMAX = sexp_t'((1 << EXP_W) - 1);
    localparam logic [W-1:0] NAN = W'(canonical_nan(EXP_W, MAN_W));

    fsm_t          state, state_n;
    op_t           op;
    logic [W-1:0]  opa, opb, res;
    logic          ovf, unf, inv, zres, eff_sub, rs;
    sexp_t         re;
    logic [MW-1:0] rm;
    logic [SW-1:0] big_m, sml_m;

    logic             sa, sb, sx;
    logic [EXP_W-1:0] ea, eb, ediff;
    logic [MAN_W-1:0] fa, fb;
    logic [SW-1:0]    ma, mb, sml_sh;
    logic             za, zb, ia, ib, na, nb, a_big;

    assign {sa, ea, fa} = opa;
    assign {eb, fb}     = opb[W-2:0];
    assign sb = opb[W-1] ^ (op == OP_SUB);
    assign sx = sa ^ sb;
    assign ma = {1'b1, fa};
    assign mb = {1'b1, fb};
    assign za = ea == '0;
    assign zb = eb == '0;
    assign ia = &ea && fa == '0;
    assign ib = &eb && fb == '0;
    assign na = &ea && fa != '0;
    assign nb = &eb && fb != '0;

    logic         sp_hit, sp_inv;
    logic [W-1:0] sp_res, inf_a, inf_b, inf_x, inf_r, zero_x;

    assign inf_a  = W'(inf(sa, EXP_W, MAN_W));
    assign inf_b  = W'(inf(sb, EXP_W, MAN_W));
    assign inf_x  = W'(inf(sx, EXP_W, MAN_W));
    assign inf_r  = W'(inf(rs, EXP_W, MAN_W));
    assign zero_x = {sx, {(W-1){1'b0}}};

    always_comb begin
        sp_hit = 1'b1;
        sp_inv = 1'b0;
        sp_res = '0;
        if (na || nb) begin
            sp_res = NAN;
            sp_inv = 1'b1;
        end else begin
            unique case (op)
                OP_MUL: begin
                    if ((za && ib) || (ia && zb)) begin
                        sp_res = NAN;
                        sp_inv = 1'b1;
                    end else if (ia || ib) sp_res = inf_x;
                    else if (za || zb)     sp_res = zero_x;
                    else                   sp_hit = 1'b0;
                end
                OP_DIV: begin
                    if ((za && zb) || (ia && ib)) begin
                        sp_res = NAN;
                        sp_inv = 1'b1;
                    end else if (ia) sp_res = inf_x;
                    else if (ib)     sp_res = zero_x;
                    else if (zb)     sp_res = inf_x;
                    else if (za)     sp_res = zero_x;
                    else             sp_hit = 1'b0;
                end
                default: begin
                    if (ia && ib && (sa != sb)) begin
                        sp_res = NAN;
                        sp_inv = 1'b1;
                    end else if (ia) sp_res = inf_a;
                    else if (ib)     sp_res = inf_b;
                    else if (za)     sp_res = {sb, opb[W-2:0]};
                    else if (zb)     sp_res = opa;
                    else             sp_hit = 1'b0;
                end
            endcase
        end
    end

    int sh;
    assign a_big = opa[W-2:0] >= opb[W-2:0];
    assign ediff = a_big ? ea - eb : eb - ea;

    always_comb begin
        sh     = (int'(ediff) > QW) ? QW : int'(ediff);
        sml_sh = (a_big ? mb : ma) >> sh;
    end

    logic [SW:0] sum;
    assign sum = eff_sub ? {1'b0, big_m} - {1'b0, sml_m}
                         : {1'b0, big_m} + {1'b0, sml_m};

    logic          div_start, div_busy, div_done;
    logic [QW-1:0] quo;

    fpu_seq_divider #(.MAN_W(MAN_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (ma),
        .divisor  (mb),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quo)
    );

    // All paths land in rm with two integer bits above the binary point.
    logic [MW-1:0] nsrc;
    int            lo;
    assign nsrc = (op == OP_DIV) ? {1'b0, quo, {(MAN_W-2){1'b0}}} : rm;
    always_comb lo = lead_one(128'(nsrc));

    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        unique case (state)
            S_IDLE:    if (io.in_valid) state_n = S_UNPACK;
            S_UNPACK: begin
                if (sp_hit)             state_n = S_SPECIAL;
                else if (op == OP_MUL)  state_n = S_MULT;
                else if (op == OP_DIV) begin
                    state_n   = S_DIV;
                    div_start = 1'b1;
                end else                state_n = S_ALIGN;
            end
            S_SPECIAL: state_n = S_DONE;
            S_ALIGN:   state_n = S_ADDSUB;
            S_ADDSUB:  state_n = S_NORM;
            S_MULT:    state_n = S_NORM;
            S_DIV:     if (div_done || !div_busy) state_n = S_NORM;
            S_NORM:    state_n = S_PACK;
            S_PACK:    state_n = S_DONE;
            S_DONE:    if (io.out_ready) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa     <= '0;
            opb     <= '0;
            op      <= OP_ADD;
            res     <= '0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
            inv     <= 1'b0;
            zres    <= 1'b0;
            eff_sub <= 1'b0;
            rs      <= 1'b0;
            re      <= '0;
            rm      <= '0;
            big_m   <= '0;
            sml_m   <= '0;
        end else begin
            unique case (state)
                S_IDLE: if (io.in_valid) begin
                    opa <= io.A;
                    opb <= io.B;
                    op  <= op_t'(io.sel);
                    ovf <= 1'b0;
                    unf <= 1'b0;
                    inv <= 1'b0;
                end
                S_UNPACK: begin
                    if (sp_hit) begin
                        res <= sp_res;
                        inv <= sp_inv;
                    end else if (op == OP_DIV) begin
                        rs <= sx;
                        re <= {2'b00, ea} - {2'b00, eb} + BIAS;
                    end
                end
                S_ALIGN: begin
                    big_m   <= a_big ? ma : mb;
                    sml_m   <= sml_sh;
                    re      <= {2'b00, a_big ? ea : eb};
                    rs      <= a_big ? sa : sb;
                    eff_sub <= sa ^ sb;
                end
                S_ADDSUB: rm <= {sum, {MAN_W{1'b0}}};
                S_MULT: begin
                    rm <= {{SW{1'b0}}, ma} * {{SW{1'b0}}, mb};
                    re <= {2'b00, ea} + {2'b00, eb} - BIAS;
                    rs <= sx;
                end
                S_NORM: begin
                    zres <= nsrc == '0;
                    rm   <= nsrc << (MW - 1 - lo);
                    re   <= re + sexp_t'(lo - (MW - 2));
                end
                S_PACK: begin
                    if (zres) res <= '0;
                    else if (re >= EMAX) begin
                        res <= inf_r;
                        ovf <= 1'b1;
                    end else if (re[EW2-1] || re == '0) begin
                        res <= {rs, {(W-1){1'b0}}};
                        unf <= 1'b1;
                    end else begin
                        res <= {rs, re[EXP_W-1:0], rm[MW-2 -: MAN_W]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.in_ready  = state == S_IDLE;
    assign io.out_valid = state == S_DONE;
    assign io.result    = res;
    assign io.overflag  = ovf;
    assign io.underflag = unf;
    assign io.invalid   = inv;

endmodule

// File: tb/tb_au_floating_point_seq.sv
// Bench for au_floating_point_seq (FP32): directed vectors, backpressure,
// mid-division reset, then random ops against a value-level model.
module tb_au_floating_point_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    au_floating_point_seq_if #(.EXP_W(8), .MAN_W(23)) io ();

    au_floating_point_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Value model: operands as integer significands times powers of two,
    // result rounded toward zero from the exact integer intermediate.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  input logic [1:0] s, output logic [31:0] r,
                                  output logic [2:0] fl, output int lat);
        logic        sa, sb, sx, sr;
        int          ea, eb, eg, el, d, k, p, be;
        logic [63:0] ma, mb, mg, ml, n, f;
        bit          za, zb, ia, ib, na, nb, spec;
        sa = a[31];
        sb = b[31] ^ (s == 2'd1);
        sx = sa ^ sb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = {40'd0, 1'b1, a[22:0]};
        mb = {40'd0, 1'b1, b[22:0]};
        za = ea == 0;
        zb = eb == 0;
        ia = ea == 255 && a[22:0] == 0;
        ib = eb == 255 && b[22:0] == 0;
        na = ea == 255 && a[22:0] != 0;
        nb = eb == 255 && b[22:0] != 0;
        r = 32'h0; fl = 3'b000; lat = 2; spec = 1; n = 0; k = 0; sr = 0;
        if (na || nb) begin r = 32'h7FC00000; fl = 3'b001; end
        else if (s == 2'd2) begin
            if ((za && ib) || (ia && zb)) begin r = 32'h7FC00000; fl = 3'b001; end
            else if (ia || ib) r = {sx, 8'hFF, 23'h0};
            else if (za || zb) r = {sx, 31'h0};
            else begin spec = 0; n = ma * mb; k = ea + eb - 300; sr = sx; lat = 4; end
        end else if (s == 2'd3) begin
            if ((za && zb) || (ia && ib)) begin r = 32'h7FC00000; fl = 3'b001; end
            else if (ia) r = {sx, 8'hFF, 23'h0};
            else if (ib) r = {sx, 31'h0};
            else if (zb) r = {sx, 8'hFF, 23'h0};
            else if (za) r = {sx, 31'h0};
            else begin spec = 0; n = (ma << 25) / mb; k = ea - eb - 25; sr = sx; lat = 29; end
        end else begin
            if (ia && ib && sa != sb) begin r = 32'h7FC00000; fl = 3'b001; end
            else if (ia) r = {sa, 8'hFF, 23'h0};
            else if (ib) r = {sb, 8'hFF, 23'h0};
            else if (za) r = {sb, b[30:0]};
            else if (zb) r = a;
            else begin
                spec = 0; lat = 5;
                if (a[30:0] >= b[30:0]) begin eg = ea; el = eb; mg = ma; ml = mb; sr = sa; end
                else begin eg = eb; el = ea; mg = mb; ml = ma; sr = sb; end
                d = eg - el;
                if (d > 26) d = 26;
                ml = ml >> d;
                n = (sa != sb) ? mg - ml : mg + ml;
                k = eg - 150;
            end
        end
        if (!spec) begin
            if (n == 0) r = 32'h0;
            else begin
                p = 63;
                while (!n[p]) p--;
                be = p + k + 127;
                if (be >= 255) begin r = {sr, 8'hFF, 23'h0}; fl = 3'b100; end
                else if (be <= 0) begin r = {sr, 31'h0}; fl = 3'b010; end
                else begin
                    f = (p >= 23) ? (n >> (p - 23)) : (n << (23 - p));
                    r = {sr, be[7:0], f[22:0]};
                end
            end
        end
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] s, input int hold, input bit fixed,
                          input logic [31:0] fr, input logic [2:0] ff);
        logic [31:0] er;
        logic [2:0]  ef;
        int          el, lat, w;
        model(a, b, s, er, ef, el);
        if (fixed) begin er = fr; ef = ff; end
        @(negedge clk);
        io.in_valid = 1'b1; io.A = a; io.B = b; io.sel = s; io.out_ready = 1'b0;
        w = 0;
        while (!io.in_ready && w < 200) begin @(negedge clk); w++; end
        check({tag, " in_ready"}, {31'd0, io.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        io.in_valid = 1'b0; io.A = $urandom; io.B = $urandom; io.sel = 2'($urandom);
        lat = 0;
        while (!io.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, 32'(lat), 32'(el));
        check({tag, " result"}, io.result, er);
        check({tag, " flags"}, {29'd0, io.overflag, io.underflag, io.invalid}, {29'd0, ef});
        for (int i = 0; i < hold; i++) begin
            io.in_valid = 1'b1; io.A = $urandom; io.B = $urandom;
            @(posedge clk); #1;
            check({tag, " held"}, {io.result[30:0], 1'b0} ^ {28'd0, io.out_valid, io.in_ready,
                  io.overflag | io.underflag | io.invalid, 1'b0},
                  {er[30:0], 1'b0} ^ {28'd0, 1'b1, 1'b0, |ef, 1'b0});
            check({tag, " held sign"}, {31'd0, io.result[31]}, {31'd0, er[31]});
        end
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;
        check({tag, " release"}, {30'd0, io.out_valid, io.in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  rs;
        int          lo, hi, seen;
        io.in_valid = 1'b0; io.A = '0; io.B = '0; io.sel = '0; io.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset hs", {30'd0, io.in_ready, io.out_valid}, 32'd2);
        check("reset res", io.result, 32'h0);
        check("reset flags", {29'd0, io.overflag, io.underflag, io.invalid}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("add",    32'h44FC6000, 32'hC4F9E000, 2'd0, 0, 1, 32'h41A00000, 3'b000);
        run_op("mul",    32'h44FC6000, 32'hC4F9E000, 2'd2, 0, 1, 32'hCA765634, 3'b000);
        run_op("div",    32'h40C00000, 32'h40400000, 2'd3, 0, 1, 32'h40000000, 3'b000);
        run_op("0xinf",  32'h00000000, 32'hFF800000, 2'd2, 0, 1, 32'h7FC00000, 3'b001);
        run_op("inf-inf",32'hFF800000, 32'h7F800000, 2'd0, 0, 1, 32'h7FC00000, 3'b001);
        run_op("ovf",    32'h7F000000, 32'h40000000, 2'd2, 0, 1, 32'h7F800000, 3'b100);
        run_op("unf",    32'h00800000, 32'h3F000000, 2'd2, 0, 1, 32'h00000000, 3'b010);
        run_op("x/0",    32'h3F800000, 32'h00000000, 2'd3, 0, 1, 32'h7F800000, 3'b000);
        run_op("cancel", 32'hBFC00000, 32'hBFC00000, 2'd1, 0, 1, 32'h00000000, 3'b000);
        run_op("0+x",    32'h00000000, 32'h40490FDB, 2'd0, 0, 1, 32'h40490FDB, 3'b000);
        run_op("0-x",    32'h00000000, 32'h3F800000, 2'd1, 0, 1, 32'hBF800000, 3'b000);
        run_op("inf+1",  32'h7F800000, 32'h3F800000, 2'd0, 0, 1, 32'h7F800000, 3'b000);
        run_op("nan",    32'h7FC12345, 32'h3F800000, 2'd0, 0, 1, 32'h7FC00000, 3'b001);
        run_op("bp",     32'h44FC6000, 32'hC4F9E000, 2'd2, 3, 1, 32'hCA765634, 3'b000);
        run_op("bp next",32'h3FC00000, 32'h40100000, 2'd0, 0, 1, 32'h40700000, 3'b000);

        @(negedge clk);
        io.in_valid = 1'b1; io.A = 32'h40C00000; io.B = 32'h40400000; io.sel = 2'd3;
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("rst div hs", {30'd0, io.in_ready, io.out_valid}, 32'd2);
        check("rst div res", io.result, 32'h0);
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (io.out_valid) seen++; end
        check("rst div quiet", 32'(seen), 32'd0);
        run_op("post rst", 32'h44FC6000, 32'hC4F9E000, 2'd0, 0, 1, 32'h41A00000, 3'b000);

        for (int i = 0; i < 80; i++) begin
            rs = 2'($urandom);
            if ($urandom_range(0, 4) == 0) begin lo = 1; hi = 254; end
            else begin lo = 100; hi = 154; end
            ra = $urandom; rb = $urandom;
            ra[30:23] = 8'($urandom_range(lo, hi));
            rb[30:23] = 8'($urandom_range(lo, hi));
            if ($urandom_range(0, 11) == 0) ra[30:0] = '0;
            if ($urandom_range(0, 11) == 0) rb[30:0] = '0;
            if ($urandom_range(0, 3) == 0) rb[30:23] = ra[30:23];
            run_op("rnd", ra, rb, rs, 0, 0, 32'h0, 3'b000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
